// File: rtl/alu_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_parser_if
// Bundles the byte stream from the UART receiver and the command/handshake
// signals toward the ALU.
//   rx_done_tick, rx_data : received byte strobe and data
//   rd                    : consumer acknowledge of the held command
//   A, B, Op              : decoded command fields
//   cmd_valid             : a complete command is held
//   err, err_code         : one-cycle error pulse and its cause
// Modports:
//   master : the UART/consumer side (drives bytes and rd)
//   slave  : the parser
// -----------------------------------------------------------------------------
interface alu_cmd_parser_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               rx_done_tick;
    logic [7:0]         rx_data;
    logic               rd;
    logic [NB_DATA-1:0] A;
    logic [NB_DATA-1:0] B;
    logic [NB_OP-1:0]   Op;
    logic               cmd_valid;
    logic               err;
    logic [2:0]         err_code;

    modport master (
        output rx_done_tick, rx_data, rd,
        input  A, B, Op, cmd_valid, err, err_code
    );

    modport slave (
        input  rx_done_tick, rx_data, rd,
        output A, B, Op, cmd_valid, err, err_code
    );
endinterface

// File: rtl/alu_cmd_parser.sv
// -----------------------------------------------------------------------------
// alu_cmd_parser
// ASCII command parser between the UART receiver and the ALU. Accumulates
// decimal operand tokens ('f' loads A, 's' loads B), decodes an operator
// symbol on 'o', and presents {A, B, Op} with cmd_valid on 'd' once all
// three fields are loaded. The consumer releases the command with rd.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : alu_cmd_parser_if.slave (byte input, command output, errors)
// Error codes: 1 OVERFLOW, 2 BADOP, 3 INCOMPLETE, 4 BUSY, 5 OVERRUN.
// -----------------------------------------------------------------------------
module alu_cmd_parser #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    alu_cmd_parser_if.slave  bus
);

    localparam int NB_ACC = NB_DATA + 4;
    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_VALID  = 2'd2;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_OVERFLOW   = 3'd1;
    localparam logic [2:0] ERR_BADOP      = 3'd2;
    localparam logic [2:0] ERR_INCOMPLETE = 3'd3;
    localparam logic [2:0] ERR_BUSY       = 3'd4;
    localparam logic [2:0] ERR_OVERRUN    = 3'd5;

    localparam logic [7:0] CH_F  = 8'h66;  // 'f'
    localparam logic [7:0] CH_S  = 8'h73;  // 's'
    localparam logic [7:0] CH_O  = 8'h6F;  // 'o'
    localparam logic [7:0] CH_D  = 8'h64;  // 'd'
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    logic [1:0]         r_state;
    logic [7:0]         r_byte;
    logic [NB_DATA-1:0] r_acc;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [7:0]         r_sym;
    logic               r_a_ld;
    logic               r_b_ld;
    logic               r_op_ld;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic               r_err;
    logic [2:0]         r_err_code;

    logic               w_is_digit;
    logic [NB_ACC-1:0]  w_acc_ext;
    logic [NB_ACC-1:0]  w_acc_next;
    logic [NB_ACC-1:0]  w_acc_max;
    logic               w_overflow;
    logic               w_op_hit;
    logic [5:0]         w_op_code;

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign w_is_digit = (r_byte >= 8'h30) && (r_byte <= 8'h39);
    assign w_acc_ext  = NB_ACC'(r_acc);
    assign w_acc_next = (w_acc_ext << 3) + (w_acc_ext << 1) + NB_ACC'(r_byte[3:0]);
    assign w_acc_max  = NB_ACC'({NB_DATA{1'b1}});
    assign w_overflow = (r_dcnt == DCNT_W'(MAX_DIGITS)) || (w_acc_next > w_acc_max);

    // Operator symbol to ALU opcode.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is
        // inferred for symbols that match no branch.
        w_op_hit  = 1'b1;
        w_op_code = 6'd0;
        case (r_sym)
            8'h2B:   w_op_code = 6'd32;  // '+'
            8'h2D:   w_op_code = 6'd34;  // '-'
            8'h26:   w_op_code = 6'd36;  // '&'
            8'h7C:   w_op_code = 6'd37;  // '|'
            8'h78:   w_op_code = 6'd38;  // 'x'
            8'h6E:   w_op_code = 6'd39;  // 'n'
            8'h61:   w_op_code = 6'd3;   // 'a'
            8'h6C:   w_op_code = 6'd2;   // 'l'
            default: w_op_hit  = 1'b0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block deliberately override
    // earlier ones (e.g. OVERRUN over a decode error).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_byte     <= 8'd0;
            r_acc      <= '0;
            r_dcnt     <= '0;
            r_sym      <= 8'd0;
            r_a_ld     <= 1'b0;
            r_b_ld     <= 1'b0;
            r_op_ld    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_done_tick) begin
                        r_byte  <= bus.rx_data;
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    r_state <= ST_IDLE;
                    if (w_is_digit) begin
                        if (w_overflow) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_OVERFLOW;
                            r_acc      <= '0;
                            r_dcnt     <= '0;
                        end else begin
                            r_acc  <= w_acc_next[NB_DATA-1:0];
                            r_dcnt <= r_dcnt + DCNT_W'(1);
                        end
                    end else begin
                        case (r_byte)
                            CH_F: begin
                                r_a    <= r_acc;
                                r_a_ld <= 1'b1;
                                r_acc  <= '0;
                                r_dcnt <= '0;
                            end
                            CH_S: begin
                                r_b    <= r_acc;
                                r_b_ld <= 1'b1;
                                r_acc  <= '0;
                                r_dcnt <= '0;
                            end
                            CH_O: begin
                                if (w_op_hit) begin
                                    r_op    <= NB_OP'(w_op_code);
                                    r_op_ld <= 1'b1;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= ERR_BADOP;
                                end
                                r_sym  <= 8'd0;
                                r_acc  <= '0;
                                r_dcnt <= '0;
                            end
                            CH_D: begin
                                if (r_a_ld && r_b_ld && r_op_ld) begin
                                    r_state <= ST_VALID;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= ERR_INCOMPLETE;
                                end
                            end
                            CH_SP, CH_CR, CH_LF: begin
                            end
                            default: begin
                                r_sym  <= r_byte;
                                r_acc  <= '0;
                                r_dcnt <= '0;
                            end
                        endcase
                    end
                    // A byte arriving while the previous one is decoded is lost.
                    if (bus.rx_done_tick) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_OVERRUN;
                    end
                end

                ST_VALID: begin
                    if (bus.rx_done_tick) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_BUSY;
                    end
                    if (bus.rd) begin
                        r_state <= ST_IDLE;
                        r_a_ld  <= 1'b0;
                        r_b_ld  <= 1'b0;
                        r_op_ld <= 1'b0;
                        r_acc   <= '0;
                        r_dcnt  <= '0;
                        r_sym   <= 8'd0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.Op        = r_op;
    assign bus.cmd_valid = (r_state == ST_VALID);
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_parser
// Directed bench for alu_cmd_parser. Two instances share the byte stream:
// dut8 (NB_DATA=8, NB_OP=6, MAX_DIGITS=3) and dut16 (NB_DATA=16, NB_OP=8,
// MAX_DIGITS=5). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_cmd_parser;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd;

    int n_checks = 0;
    int n_pass   = 0;

    logic       mid_err, mid_valid, last_err, last_err16;
    logic [2:0] mid_code, last_code, last_code16;

    alu_cmd_parser_if #(.NB_DATA(8),  .NB_OP(6)) bus8  ();
    alu_cmd_parser_if #(.NB_DATA(16), .NB_OP(8)) bus16 ();

    assign bus8.rx_done_tick  = rx_done_tick;
    assign bus8.rx_data       = rx_data;
    assign bus8.rd            = rd;
    assign bus16.rx_done_tick = rx_done_tick;
    assign bus16.rx_data      = rx_data;
    assign bus16.rd           = rd;

    alu_cmd_parser #(.NB_DATA(8), .NB_OP(6), .MAX_DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    alu_cmd_parser #(.NB_DATA(16), .NB_OP(8), .MAX_DIGITS(5)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // edge on which the byte has been decoded.
    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        mid_err   = bus8.err;
        mid_code  = bus8.err_code;
        mid_valid = bus8.cmd_valid;
        @(posedge clk); #1;
        last_err    = bus8.err;
        last_code   = bus8.err_code;
        last_err16  = bus16.err;
        last_code16 = bus16.err_code;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    // Two ticks on consecutive cycles: the second lands in DECODE.
    task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2);
        rx_data      = b1;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_data = b2;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        last_err  = bus8.err;
        last_code = bus8.err_code;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'd0;
        rd           = 1'b0;

        // Reset state
        #12;
        check("rst_A",         32'(bus8.A),         0);
        check("rst_B",         32'(bus8.B),         0);
        check("rst_Op",        32'(bus8.Op),        0);
        check("rst_cmd_valid", 32'(bus8.cmd_valid), 0);
        check("rst_err",       32'(bus8.err),       0);
        check("rst_err_code",  32'(bus8.err_code),  0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Nominal command
        send_str("123f045s+od");
        check("nom_valid_latency", 32'(mid_valid), 0);
        check("nom_cmd_valid", 32'(bus8.cmd_valid), 1);
        check("nom_A",  32'(bus8.A),  123);
        check("nom_B",  32'(bus8.B),  45);
        check("nom_Op", 32'(bus8.Op), 32);
        pulse_rd();
        check("rd_cmd_valid", 32'(bus8.cmd_valid), 0);
        check("rd_A_held",  32'(bus8.A),  123);
        check("rd_B_held",  32'(bus8.B),  45);
        check("rd_Op_held", 32'(bus8.Op), 32);

        // Overflow by value
        send_str("25");
        check("ovf_25_noerr", 32'(last_err), 0);
        send_byte("6");
        check("ovf_256_err",  32'(last_err),  1);
        check("ovf_256_code", 32'(last_code), 1);
        send_byte("f");
        check("ovf_A_zero", 32'(bus8.A), 0);
        check("err_falls", 32'(last_err), 0);
        // Overflow by digit count
        send_str("123");
        check("ovf_3dig_noerr", 32'(last_err), 0);
        send_byte("4");
        check("ovf_4dig_err",  32'(last_err),  1);
        check("ovf_4dig_code", 32'(last_code), 1);

        // Bad opcode
        send_str("?o");
        check("badop_err",  32'(last_err),  1);
        check("badop_code", 32'(last_code), 2);
        check("badop_Op_kept", 32'(bus8.Op), 32);

        // Incomplete
        send_str("7f9sd");
        check("inc_code",  32'(last_code), 3);
        check("inc_valid", 32'(bus8.cmd_valid), 0);
        check("inc_A", 32'(bus8.A), 7);
        check("inc_B", 32'(bus8.B), 9);
        send_byte("-");
        check("code_clears_err",  32'(mid_err),  0);
        check("code_clears_code", 32'(mid_code), 0);
        send_str("od");
        check("inc_fix_valid", 32'(bus8.cmd_valid), 1);
        check("inc_fix_Op",    32'(bus8.Op), 34);

        // Busy: byte during VALID
        send_byte("5");
        check("busy_err",  32'(mid_err),  1);
        check("busy_code", 32'(mid_code), 4);
        check("busy_valid_kept", 32'(bus8.cmd_valid), 1);
        check("busy_A", 32'(bus8.A), 7);
        check("busy_B", 32'(bus8.B), 9);
        check("busy_Op", 32'(bus8.Op), 34);
        // Busy and rd in the same cycle: byte dropped, rd honoured
        rd = 1'b1;
        send_byte("1");
        rd = 1'b0;
        check("busy_rd_code",  32'(mid_code), 4);
        check("busy_rd_valid", 32'(bus8.cmd_valid), 0);

        // Overrun: second byte lost
        send_pair("3", "4");
        check("ovr_err",  32'(last_err),  1);
        check("ovr_code", 32'(last_code), 5);
        send_byte("f");
        check("ovr_byte_lost", 32'(bus8.A), 3);
        // Overrun has priority over BADOP
        send_byte("?");
        send_pair("o", "x");
        check("ovr_prio_code", 32'(last_code), 5);
        check("ovr_prio_Op",   32'(bus8.Op), 34);

        // Reset mid-VALID, between edges
        send_str("1s+od");
        check("pre_rst_valid", 32'(bus8.cmd_valid), 1);
        check("pre_rst_A", 32'(bus8.A), 3);
        #3 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus8.cmd_valid), 0);
        check("async_rst_A",  32'(bus8.A),  0);
        check("async_rst_B",  32'(bus8.B),  0);
        check("async_rst_Op", 32'(bus8.Op), 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        send_str("5f5s&od");
        check("post_rst_valid", 32'(bus8.cmd_valid), 1);
        check("post_rst_A",  32'(bus8.A),  5);
        check("post_rst_B",  32'(bus8.B),  5);
        check("post_rst_Op", 32'(bus8.Op), 36);

        // Wide instance: clean start
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        send_str("65535f");
        check("w16_A_max",  32'(bus16.A), 65535);
        check("w16_noerr",  32'(last_err16), 0);
        send_str("6553");
        send_byte("6");
        check("w16_ovf_err",  32'(last_err16),  1);
        check("w16_ovf_code", 32'(last_code16), 1);
        send_byte("f");
        check("w16_ovf_A", 32'(bus16.A), 0);
        send_str("no");
        check("w16_Op_n", 32'(bus16.Op), 39);
        check("w8_Op_n",  32'(bus8.Op),  39);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_parser.md
# alu_cmd_parser

Parametrised ASCII command parser between the UART receiver and the ALU. It consumes received bytes, accumulates multi-digit decimal operands with range checking, decodes the operator symbol, and presents a complete {A, B, Op} command under a valid/read handshake. Malformed input is reported through a one-cycle error pulse and a cause code.

## Interface
- `NB_DATA`, 8: operand width in bits. Each operand accepts values 0 .. 2^NB_DATA-1.
- `NB_OP`, 6: opcode width. Must be at least 6; codes are zero-extended.
- `MAX_DIGITS`, 3: maximum decimal digits per operand token.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. 0 resets the block.
- `rx_done_tick` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `rd` in 1: consumer acknowledge of the current command.
- `A` out NB_DATA: first operand.
- `B` out NB_DATA: second operand.
- `Op` out NB_OP: ALU opcode.
- `cmd_valid` out 1: a complete command is held.
- `err` out 1: one-cycle error pulse.
- `err_code` out 3: error cause, valid while `err`=1.
  - 1 OVERFLOW, 2 BADOP, 3 INCOMPLETE, 4 BUSY, 5 OVERRUN.

## Operation
- **States**
  - IDLE: waiting for a byte.
  - DECODE: act on the captured byte.
  - VALID: command held.
- **IDLE**
  - On `rx_done_tick`: capture `rx_data` into `byte_q` and go to DECODE. Otherwise stay.
- **DECODE** (one cycle)
  - Returns to IDLE, except after a successful 'd', which goes to VALID.
  - Digits '0'-'9' (48-57):
    - Compute `acc_next = acc*10 + (byte-48)` in NB_DATA+4 bits.
    - If `dcnt == MAX_DIGITS` or `acc_next > 2^NB_DATA-1`: raise OVERFLOW, clear `acc` and `dcnt`, drop the token.
    - Otherwise: `acc <= acc_next`, `dcnt++`.
  - 'f' (102): `A <= acc`, set `a_ld`, clear `acc` and `dcnt`. An empty token (`dcnt`=0) loads 0.
  - 's' (115): `B <= acc`, set `b_ld`, clear `acc` and `dcnt`.
  - 'o' (111): decode `sym`, then clear `sym`, `acc`, `dcnt`.
    - '+' → 32, '-' → 34, '&' → 36, '|' → 37, 'x' → 38, 'n' → 39, 'a' → 3, 'l' → 2.
    - On a match: `Op <=` code, set `op_ld`.
    - `sym`=0 or any other value: raise BADOP; `Op` and `op_ld` are unchanged.
  - 'd' (100):
    - If `a_ld & b_ld & op_ld`: go to VALID.
    - Otherwise: raise INCOMPLETE, stay in IDLE; loaded flags are kept.
  - Space, CR, LF (32, 13, 10): ignored. No state change.
  - Any other byte: `sym <= byte`, clear `acc` and `dcnt`.
- **VALID**
  - `cmd_valid`=1; `A`, `B`, `Op` are stable.
  - On `rd`=1: go to IDLE, clear `a_ld`, `b_ld`, `op_ld`, `acc`, `dcnt`, `sym`.
  - `A`, `B`, `Op` keep their values until overwritten.
  - `rx_done_tick` in VALID: byte dropped, raise BUSY.
  - If `rx_done_tick` and `rd` arrive in the same cycle: the byte is dropped with BUSY, and `rd` is still honoured.
- `rd` outside VALID is ignored.
- Errors never block parsing. Parsing continues with the next byte.

## Timing
- **Reset values** (`reset`=0):
  - `A`=0, `B`=0, `Op`=0, `cmd_valid`=0, `err`=0, `err_code`=0.
  - State IDLE; `acc`, `dcnt`, `sym` and the loaded flags all 0.
- Assertion of `reset` mid-command, including in VALID, clears everything immediately with no clock needed.
- **Latency:** for `rx_done_tick` high in cycle n:
  - The byte is captured at edge n.
  - DECODE runs in cycle n+1.
  - Register updates, `err`, and `cmd_valid` appear after edge n+1. Latency is 2 cycles.
- `err` is high for exactly one cycle, and `err_code` is registered with it. `err_code` returns to 0 when `err` falls.
- **Byte spacing:** `rx_done_tick` spacing is at least 2 cycles. A tick during DECODE drops that byte and raises OVERRUN. DECODE still completes for the earlier byte, and OVERRUN takes priority on `err_code`.
- `cmd_valid` falls on the edge that samples `rd`=1. A new command can start being parsed in the next cycle.

## Test plan
- **Nominal command:** bytes "123f045s+od", `rd` held 0 → `cmd_valid`=1 two cycles after the 'd' tick, with `A`=123, `B`=45, `Op`=32. Then `rd` pulse → `cmd_valid`=0 next edge and `A`/`B`/`Op` held.
- **Overflow:** "256f" (NB_DATA=8) → OVERFLOW on the '6' byte, then `A`=0 after 'f'. Also "1234" → OVERFLOW on '4'.
- **Bad opcode and incomplete:** "?o" → BADOP with `Op` unchanged. "7f9sd" with no operator → INCOMPLETE, `cmd_valid` stays 0. Adding "-od" afterwards → `cmd_valid`=1, `Op`=34.
- **Busy and overrun:** a byte during VALID → BUSY, and `A`/`B`/`Op` unchanged. Ticks 1 cycle apart → OVERRUN, second byte lost.
- **Reset mid-operation:** assert `reset`=0 in VALID between clock edges → all outputs 0 immediately. Release, then send "5f5s&od" → `A`=5, `B`=5, `Op`=36.
- **Parametrisation:** NB_DATA=16, MAX_DIGITS=5 → "65535f" loads 65535; "65536f" gives OVERFLOW. NB_OP=8 → `Op`=8'd39 for 'n'.
